// File: rtl/pulse_pacer_mc.sv
// Multi-channel pulse pacer: replays each request pulse as a stretched, gap-guaranteed pulse.
// Latency: request at cycle t appears on out_pulse at t+1; back-to-back rate 1 per HIGH_CYC+LOW_CYC.
// Backpressure: none upstream; bursts queue in a saturating per-channel counter, drops set sticky ovf.
// Optional: define PULSE_PACER_TOGGLE_EN for a toggle (NRZ) out_pulse instead of return-to-zero.
module pulse_pacer_mc #(
  parameter int CH       = 4,
  parameter int CNT_W    = 4,
  parameter int HIGH_CYC = 3,
  parameter int LOW_CYC  = 3
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic [CH-1:0] in_pulse,
  input  logic [CH-1:0] ovf_clr,
  output logic [CH-1:0] out_pulse,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] ovf
);

  localparam int MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [TW-1:0]    T_HIGH   = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0]    T_LOW    = TW'(LOW_CYC - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Zero-length phases would make the pacing meaningless
  if (HIGH_CYC < 1 || LOW_CYC < 1) begin : g_bad_cfg
    $error("pulse_pacer_mc: HIGH_CYC and LOW_CYC must both be >= 1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [TW-1:0]    tmr, tmr_nxt;
    logic [CNT_W-1:0] pend, pend_nxt;
    logic             take, avail, drop;
    logic             out_q, out_nxt;
    logic             busy_q, busy_nxt;
    logic             ovf_q, ovf_nxt;

    // Phase sequencing: an event is taken on entry to HIGH from IDLE or at the end of LOW
    always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      take      = 1'b0;
      avail     = (pend != '0) | in_pulse[i];
      case (state)
        IDLE: begin
          if (avail) begin
            take      = 1'b1;
            state_nxt = HIGH;
            tmr_nxt   = T_HIGH;
          end
        end
        HIGH: begin
          if (tmr == '0) begin
            state_nxt = LOW;
            tmr_nxt   = T_LOW;
          end else begin
            tmr_nxt = tmr - TW'(1);
          end
        end
        LOW: begin
          if (tmr == '0) begin
            if (avail) begin
              take      = 1'b1;
              state_nxt = HIGH;
              tmr_nxt   = T_HIGH;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tmr_nxt = tmr - TW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Pending counter, overflow flag and registered output values
    always_comb begin
      pend_nxt = pend;
      drop     = 1'b0;
      // take with pend==0 implies a live input, so the decrement branch never underflows
      if (in_pulse[i] && !take) begin
        if (pend == PEND_MAX) drop = 1'b1;
        else                  pend_nxt = pend + CNT_W'(1);
      end else if (!in_pulse[i] && take) begin
        pend_nxt = pend - CNT_W'(1);
      end
      // a drop in the same cycle as a clear keeps the flag set
      ovf_nxt  = drop | (ovf_q & ~ovf_clr[i]);
      busy_nxt = (state_nxt != IDLE) | (pend_nxt != '0);
`ifdef PULSE_PACER_TOGGLE_EN
      out_nxt  = out_q ^ take;
`else
      out_nxt  = (state_nxt == HIGH);
`endif
    end

    // Channel state register; reset discards everything in flight
    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        state  <= IDLE;
        tmr    <= '0;
        pend   <= '0;
        out_q  <= 1'b0;
        busy_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        state  <= state_nxt;
        tmr    <= tmr_nxt;
        pend   <= pend_nxt;
        out_q  <= out_nxt;
        busy_q <= busy_nxt;
        ovf_q  <= ovf_nxt;
      end
    end

    assign out_pulse[i] = out_q;
    assign busy[i]      = busy_q;
    assign ovf[i]       = ovf_q;
  end

endmodule
